// File: rtl/vrased_reset_ctrl_pkg.sv
// vrased_reset_ctrl shared definitions:
// state encodings, violation bit indices, widths.
package vrased_reset_ctrl_pkg;

  localparam int NUM_VIOL = 7;
  localparam int CNT_W    = 8;

  localparam int VIOL_X_STACK     = 0;
  localparam int VIOL_AC          = 1;
  localparam int VIOL_ATOMICITY   = 2;
  localparam int VIOL_DMA_AC      = 3;
  localparam int VIOL_DMA_DETECT  = 4;
  localparam int VIOL_DMA_X_STACK = 5;
  localparam int VIOL_PROOF_RESET = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAIT_PC = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/vrased_reset_ctrl_hold_cnt.sv
// rst_hold_cnt: 8-bit loadable down-counter
// with a zero flag; load wins over decrement.
module rst_hold_cnt
  import vrased_reset_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // count register: load, else decrement, never underflow
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl: VRASED CPU reset sequencer.
// Violation log built only with VRASED_VIOL_LOG_EN.
module vrased_reset_ctrl
  import vrased_reset_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         pc,
  input  logic [NUM_VIOL-1:0] viol,
  input  logic                cause_clr,
  output logic                cpu_reset,
  output logic                busy,
  output logic [NUM_VIOL-1:0] cause,
  output logic                cause_valid,
  output logic [CNT_W-1:0]    viol_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic             any_viol;
  logic             event_hit;
  logic             in_hold;
  logic             hold_done;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign any_viol  = |viol;
  assign in_hold   = (state_q == ST_HOLD);
  assign event_hit = any_viol && !in_hold;
  // The combinational event cycle is the first
  // high cycle, so HOLD ends one count early.
  assign hold_done = cnt_zero || (cnt == 8'd1);
  assign cnt_load  = event_hit;
  assign cnt_dec   = in_hold;

  rst_hold_cnt u_hold_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: a violation beats a pc match
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (event_hit) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done) state_d = ST_WAIT_PC;
      end
      ST_WAIT_PC: begin
        if (event_hit) begin
          state_d = ST_HOLD;
        end else if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // zero-latency reset; block reset drops HOLD now
  always_comb begin
    cpu_reset = any_viol || (in_hold && !reset);
    busy      = (state_q != ST_IDLE);
  end

`ifdef VRASED_VIOL_LOG_EN
  logic [NUM_VIOL-1:0] cause_q;
  logic [CNT_W-1:0]    count_q;

  // sticky cause and saturating count;
  // a same-cycle event beats cause_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_q <= '0;
      count_q <= '0;
    end else begin
      if (cause_clr) begin
        cause_q <= viol;
        count_q <= event_hit ? 8'd1 : 8'd0;
      end else begin
        cause_q <= cause_q | viol;
        if (event_hit && (count_q != CNT_MAX)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign cause       = cause_q;
  assign cause_valid = |cause_q;
  assign viol_count  = count_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr;
  assign cause       = '0;
  assign cause_valid = 1'b0;
  assign viol_count  = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// tb_vrased_reset_ctrl: scoreboard bench with
// a cycle-level behavioural reference model.
module tb_vrased_reset_ctrl;

  localparam int          HC = 4;
  localparam logic [15:0] RH = 16'h0000;

  typedef struct packed {
    logic       skip;
    logic       cr;
    logic       bsy;
    logic [6:0] cause;
    logic       cv;
    logic [7:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [6:0]  viol;
  logic        cause_clr;
  logic        cpu_reset;
  logic        busy;
  logic [6:0]  cause;
  logic        cause_valid;
  logic [7:0]  viol_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  // model state
  bit   m_hold    = 0;
  bit   m_wait    = 0;
  int   m_left    = 0;
  int   m_cause   = 0;
  int   m_count   = 0;

  vrased_reset_ctrl #(
    .RESET_HANDLER (RH),
    .HOLD_CYCLES   (HC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .viol        (viol),
    .cause_clr   (cause_clr),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .cause       (cause),
    .cause_valid (cause_valid),
    .viol_count  (viol_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [6:0] v,
                     input logic [15:0] p,
                     input bit c,
                     input bit r);
    exp_t e;
    bit   ev;
    @(posedge clk);
    #1;
    viol = v; pc = p; cause_clr = c; reset = r;
    e.skip = r;
    e.cr   = m_hold || (v != 0);
    e.bsy  = m_hold || m_wait;
`ifdef VRASED_VIOL_LOG_EN
    e.cause = 7'(m_cause);
    e.cv    = (m_cause != 0);
    e.cnt   = 8'(m_count);
`else
    e.cause = '0;
    e.cv    = 1'b0;
    e.cnt   = '0;
`endif
    sb.push_back(e);
    ev = (v != 0) && !m_hold;
    if (r) begin
      m_hold = 0; m_wait = 0; m_left = 0;
      m_cause = 0; m_count = 0;
    end else begin
      if (c) begin
        m_cause = 0; m_count = 0;
      end
      m_cause = m_cause | int'(v);
      if (ev && m_count < 255) m_count++;
      if (m_hold) begin
        m_left--;
        if (m_left == 0) begin
          m_hold = 0; m_wait = 1;
        end
      end else if (ev) begin
        m_hold = 1; m_wait = 0;
        m_left = (HC > 1) ? HC - 1 : 1;
      end else if (m_wait && p == RH) begin
        m_wait = 0;
      end
    end
  endtask

  task automatic idle(input int n,
                      input logic [15:0] p);
    for (int i = 0; i < n; i++) cyc(7'h0, p, 0, 0);
  endtask

  // monitor: one expected record per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.skip) begin
          n_checks++;
          if (cpu_reset === e.cr && busy === e.bsy &&
              cause === e.cause &&
              cause_valid === e.cv &&
              viol_count === e.cnt) begin
            n_pass++;
          end else begin
            $display("FAIL outputs t=%0t got cr=%b busy=%b cause=%h cv=%b cnt=%0d exp cr=%b busy=%b cause=%h cv=%b cnt=%0d",
              $time, cpu_reset, busy, cause,
              cause_valid, viol_count, e.cr, e.bsy,
              e.cause, e.cv, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    logic [6:0]  rv;
    logic [15:0] rp;
    viol = '0; pc = 16'h1234;
    cause_clr = 0; reset = 1;
    cyc(7'h0, 16'h1234, 0, 1);
    cyc(7'h0, 16'h1234, 0, 1);
    idle(2, 16'h1234);
    // single AC event, extra X_stack mid-hold
    cyc(7'h02, 16'h1234, 0, 0);
    idle(1, 16'h1234);
    cyc(7'h01, 16'h1234, 0, 0);
    idle(3, 16'h1234);
    idle(2, RH);
    // event in WAIT_PC beats pc match
    cyc(7'h02, 16'h1234, 0, 0);
    idle(4, 16'h1234);
    cyc(7'h04, RH, 0, 0);
    idle(5, 16'h1234);
    idle(2, RH);
    // saturation
    for (int i = 0; i < 300; i++) begin
      cyc(7'h01, 16'h1234, 0, 0);
      idle(3, 16'h1234);
    end
    idle(1, 16'h1234);
    cyc(7'h40, 16'h1234, 1, 0);
    idle(5, 16'h1234);
    idle(2, RH);
    // block reset in first HOLD cycle
    cyc(7'h08, 16'h1234, 0, 0);
    cyc(7'h00, 16'h1234, 0, 1);
    idle(3, 16'h1234);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 5) == 0) ?
           7'($urandom_range(1, 127)) : 7'h0;
      rp = ($urandom_range(0, 2) == 0) ?
           RH : 16'($urandom_range(1, 65535));
      cyc(rv, rp, ($urandom_range(0, 40) == 0),
          ($urandom_range(0, 150) == 0));
    end
    idle(2, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d left exp 0",
               sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
